tap_serializer: RTL and testbench

TAP_SERIALIZER -- requirements
Module: tap_serializer

---
 rtl/tap_serializer_pkg.sv | 21 ++
 rtl/tap_serializer_last_scan.sv | 36 +++
 rtl/tap_serializer.sv | 174 +++++++++++++++++
 tb/tb_tap_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_serializer_pkg.sv
// Shared definitions for the tap serializer.
//   state_t    : serializer states (IDLE / STREAM / DONE)
//   TAP_W      : width of one tap entry
//   ELIG_MASK  : bits of an entry that must be non-zero for it to be emitted
//   is_eligible: basic eligibility test (value filter only, no dedup)
package tap_serializer_pkg;

  localparam int         TAP_W     = 8;
  localparam logic [2:0] ELIG_MASK = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic is_eligible(input logic [TAP_W-1:0] value);
    return (value[2:0] & ELIG_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/tap_serializer_last_scan.sv
// tap_last_scan: combinational reduction telling whether any eligible entry
// remains strictly above the current pointer.
// Ports:
//   taps : latched tap vector, entry k at [(k+1)*TAP_W-1 -: TAP_W]
//   ptr  : current entry pointer
//   seen : per-value suppression mask indexed by entry[2:0]; bit 0 unused
//          (value 0 is never eligible). All-zero when dedup is disabled.
//   last : 1 when no eligible, unsuppressed entry exists above ptr
module tap_last_scan
  import tap_serializer_pkg::*;
#(
  parameter int NUM_OF_TAPS = 15,
  parameter int PTR_W       = 4
) (
  input  logic [NUM_OF_TAPS*TAP_W-1:0] taps,
  input  logic [PTR_W-1:0]             ptr,
  input  logic [7:0]                   seen,
  output logic                         last
);

  logic any_left;

  always_comb begin
    any_left = 1'b0;
    for (int k = 0; k < NUM_OF_TAPS; k++) begin
      if ((PTR_W'(k) > ptr) &&
          is_eligible(taps[k*TAP_W +: TAP_W]) &&
          !seen[taps[k*TAP_W +: 3]]) begin
        any_left = 1'b1;
      end
    end
  end

  assign last = ~any_left;

endmodule

// File: rtl/tap_serializer.sv
// tap_serializer: captures a vector of NUM_OF_TAPS 8-bit taps on load and
// streams the eligible ones (low 3 bits non-zero) out over a valid/ready
// handshake, one entry at a time in index order.
// Optional feature: define TAP_DEDUP_EN to suppress entries whose low 3-bit
// value has already been transferred since the last load.
// Ports:
//   clk, res      : clock, synchronous active-high reset
//   ena           : global enable, all state holds when low
//   taps_in, load : tap vector and capture request (honoured in IDLE/DONE)
//   tap_out, tap_idx, tap_last, tap_valid / tap_ready : output handshake
//   busy, done    : high in STREAM / DONE respectively
//   emit_cnt      : number of taps transferred since the last load
// SIZE is carried only for register-size consistency with neighbouring
// blocks and has no effect here.
module tap_serializer
  import tap_serializer_pkg::*;
#(
  parameter int NUM_OF_TAPS = 15,
  parameter int SIZE        = 32
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         ena,
  input  logic [NUM_OF_TAPS*TAP_W-1:0] taps_in,
  input  logic                         load,
  output logic [TAP_W-1:0]             tap_out,
  output logic [7:0]                   tap_idx,
  output logic                         tap_valid,
  input  logic                         tap_ready,
  output logic                         tap_last,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   emit_cnt
);

  localparam int              PTR_W    = $clog2(NUM_OF_TAPS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_OF_TAPS - 1);
  localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(NUM_OF_TAPS);

  state_t                       state_q, state_d;
  logic [NUM_OF_TAPS*TAP_W-1:0] taps_q;
  logic [PTR_W-1:0]             ptr;
  logic [TAP_W-1:0]             cur_tap;
  logic                         cur_ok;
  logic [7:0]                   scan_seen;
  logic                         scan_last;
  logic                         do_load, do_present, do_skip, do_xfer;

  // Mux out the entry at ptr; an out-of-range ptr reads as zero.
  always_comb begin
    cur_tap = '0;
    for (int k = 0; k < NUM_OF_TAPS; k++) begin
      if (PTR_W'(k) == ptr) cur_tap = taps_q[k*TAP_W +: TAP_W];
    end
  end

`ifdef TAP_DEDUP_EN
  logic [6:0] seen_q;
  logic [7:0] seen_ext;
  logic [7:0] seen_next;

  assign seen_ext  = {seen_q, 1'b0};
  assign seen_next = seen_ext | (8'b1 << tap_out[2:0]);
  assign cur_ok    = is_eligible(cur_tap) && !seen_ext[cur_tap[2:0]];
  // The entry being presented will be seen once it transfers, so later
  // repeats of its value cannot count as "remaining".
  assign scan_seen = seen_ext | (8'b1 << cur_tap[2:0]);

  // Seen-mask over values 1..7, cleared on load and marked on each transfer.
  always_ff @(posedge clk) begin
    if (res) begin
      seen_q <= '0;
    end else if (ena) begin
      if (do_load)      seen_q <= '0;
      else if (do_xfer) seen_q <= seen_next[7:1];
    end
  end
`else
  assign cur_ok    = is_eligible(cur_tap);
  assign scan_seen = 8'b0;
`endif

  tap_last_scan #(
    .NUM_OF_TAPS (NUM_OF_TAPS),
    .PTR_W       (PTR_W)
  ) u_last_scan (
    .taps (taps_q),
    .ptr  (ptr),
    .seen (scan_seen),
    .last (scan_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (res)      state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  // Next-state and datapath strobes. With no tap pending, each cycle either
  // presents the entry at ptr or skips it; a pending tap waits for ready.
  always_comb begin
    state_d    = state_q;
    do_load    = 1'b0;
    do_present = 1'b0;
    do_skip    = 1'b0;
    do_xfer    = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            do_load = 1'b1;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (tap_valid) begin
            if (tap_ready) begin
              do_xfer = 1'b1;
              if (tap_last) state_d = DONE;
            end
          end else if (ptr >= END_PTR) begin
            state_d = DONE;
          end else if (cur_ok) begin
            do_present = 1'b1;
          end else begin
            do_skip = 1'b1;
            if (ptr == LAST_PTR) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers; strobes are already qualified by ena.
  always_ff @(posedge clk) begin
    if (res) begin
      taps_q    <= '0;
      ptr       <= '0;
      tap_out   <= '0;
      tap_idx   <= '0;
      tap_valid <= 1'b0;
      tap_last  <= 1'b0;
      emit_cnt  <= '0;
    end else begin
      if (do_load) begin
        taps_q    <= taps_in;
        ptr       <= '0;
        emit_cnt  <= '0;
        tap_valid <= 1'b0;
        tap_last  <= 1'b0;
      end
      if (do_present) begin
        tap_out   <= cur_tap;
        tap_idx   <= 8'(ptr);
        tap_valid <= 1'b1;
        tap_last  <= scan_last;
      end
      if (do_skip) begin
        ptr <= ptr + 1'b1;
      end
      if (do_xfer) begin
        tap_valid <= 1'b0;
        tap_last  <= 1'b0;
        ptr       <= ptr + 1'b1;
        emit_cnt  <= emit_cnt + 8'd1;
      end
    end
  end

  assign busy = (state_q == STREAM);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_tap_serializer.sv
// Self-checking bench for tap_serializer with NUM_OF_TAPS=4. A reference
// model computes the expected tap list for each load and queues it; a
// monitor pops and compares on every handshake and checks output stability
// while a tap is stalled. Works with or without TAP_DEDUP_EN.
module tb_tap_serializer;

  localparam int N = 4;
`ifdef TAP_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           res, ena, load, tap_ready;
  logic [N*8-1:0] taps_in;
  logic [7:0]     tap_out, tap_idx, emit_cnt;
  logic           tap_valid, tap_last, busy, done;

  typedef struct {
    logic [7:0] val;
    logic [7:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_n;
  int   xfer_count   = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  tap_serializer #(
    .NUM_OF_TAPS (N),
    .SIZE        (32)
  ) dut (
    .clk       (clk),
    .res       (res),
    .ena       (ena),
    .taps_in   (taps_in),
    .load      (load),
    .tap_out   (tap_out),
    .tap_idx   (tap_idx),
    .tap_valid (tap_valid),
    .tap_ready (tap_ready),
    .tap_last  (tap_last),
    .busy      (busy),
    .done      (done),
    .emit_cnt  (emit_cnt)
  );

  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: walk the entries in order, keep those whose low three
  // bits are non-zero (and, with dedup, whose value has not appeared yet);
  // the final kept entry is the last one.
  task automatic modelLoad(input logic [N*8-1:0] vec);
    exp_t       items[$];
    exp_t       e;
    bit   [7:0] seen;
    logic [7:0] v;
    seen = '0;
    for (int k = 0; k < N; k++) begin
      v = vec[k*8 +: 8];
      if (v[2:0] != 3'd0 && !(DEDUP && seen[v[2:0]])) begin
        e.val  = v;
        e.idx  = 8'(k);
        e.last = 1'b0;
        items.push_back(e);
        seen[v[2:0]] = 1'b1;
      end
    end
    if (items.size() > 0) items[items.size()-1].last = 1'b1;
    exp_n = items.size();
    foreach (items[i]) exp_q.push_back(items[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one load (called at posedge+1) and queue its expected taps.
  task automatic applyStimulus(input logic [N*8-1:0] vec);
    ena     = 1'b1;
    modelLoad(vec);
    taps_in = vec;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    int n;
    n = 0;
    while (!done && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic finishLoad();
    checkOutput("emit_cnt", {24'd0, emit_cnt}, exp_n);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    checkOutput("busy_low", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: decoupled from stimulus, checks every handshake and stall.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_out, prev_idx;
  logic       prev_last;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          checkOutput("hold_valid", {31'd0, tap_valid}, 32'd1);
          checkOutput("hold_out", {24'd0, tap_out}, {24'd0, prev_out});
          checkOutput("hold_idx", {24'd0, tap_idx}, {24'd0, prev_idx});
          checkOutput("hold_last", {31'd0, tap_last}, {31'd0, prev_last});
        end
        if (tap_valid && tap_ready && ena) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_tap: got %0h idx %0d, expected none", tap_out, tap_idx);
          end else begin
            e = exp_q.pop_front();
            checkOutput("tap_out", {24'd0, tap_out}, {24'd0, e.val});
            checkOutput("tap_idx", {24'd0, tap_idx}, {24'd0, e.idx});
            checkOutput("tap_last", {31'd0, tap_last}, {31'd0, e.last});
          end
          xfer_count++;
        end
        prev_hold = tap_valid && !(tap_ready && ena);
        prev_out  = tap_out;
        prev_idx  = tap_idx;
        prev_last = tap_last;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int             n;
    int             base;
    logic [N*8-1:0] vec;

    res = 1'b1; ena = 1'b0; load = 1'b0; tap_ready = 1'b0; taps_in = '0;
    tick(); tick();
    checkOutput("rst_tap_out", {24'd0, tap_out}, 32'd0);
    checkOutput("rst_tap_idx", {24'd0, tap_idx}, 32'd0);
    checkOutput("rst_valid", {31'd0, tap_valid}, 32'd0);
    checkOutput("rst_last", {31'd0, tap_last}, 32'd0);
    checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("rst_emit_cnt", {24'd0, emit_cnt}, 32'd0);
    res = 1'b0;
    tick();

    // Basic stream with ready held high, including first-tap latency.
    $display("[TB] basic stream");
    tap_ready = 1'b1;
    applyStimulus(32'h07_00_03_01);
    checkOutput("latency_cycle1_valid", {31'd0, tap_valid}, 32'd0);
    checkOutput("latency_cycle1_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("latency_cycle2_valid", {31'd0, tap_valid}, 32'd1);
    waitDone(40);
    finishLoad();
    checkOutput("basic_count", {24'd0, emit_cnt}, 32'd3);
    tick(); tick();
    checkOutput("done_sticky", {31'd0, done}, 32'd1);

    // Backpressure on the first tap for five cycles.
    $display("[TB] backpressure");
    tap_ready = 1'b0;
    applyStimulus(32'h07_00_03_01);
    tick();
    repeat (5) tick();
    checkOutput("stall_out", {24'd0, tap_out}, 32'h01);
    tap_ready = 1'b1;
    waitDone(40);
    finishLoad();

    // All entries ineligible.
    $display("[TB] empty vector");
    applyStimulus(32'h0);
    waitDone(5);
    finishLoad();

    // Reset after the second transfer, then restart.
    $display("[TB] mid-stream reset");
    base = xfer_count;
    applyStimulus(32'h07_00_03_01);
    n = 0;
    while (xfer_count < base + 2 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("second_xfer_seen", (xfer_count >= base + 2) ? 32'd1 : 32'd0, 32'd1);
    res = 1'b1;
    exp_q.delete();
    tick();
    checkOutput("mrst_tap_out", {24'd0, tap_out}, 32'd0);
    checkOutput("mrst_tap_idx", {24'd0, tap_idx}, 32'd0);
    checkOutput("mrst_valid_last", {30'd0, tap_valid, tap_last}, 32'd0);
    checkOutput("mrst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("mrst_emit_cnt", {24'd0, emit_cnt}, 32'd0);
    res = 1'b0;
    applyStimulus(32'h07_00_03_01);
    tick();
    checkOutput("restart_idx", {24'd0, tap_idx}, 32'd0);
    checkOutput("restart_valid", {31'd0, tap_valid}, 32'd1);
    waitDone(40);
    finishLoad();

    // Repeated values: dedup keeps 03 and 05 only.
    $display("[TB] repeated values");
    applyStimulus(32'h03_05_03_03);
    waitDone(40);
    finishLoad();
    checkOutput("repeat_count", {24'd0, emit_cnt}, DEDUP ? 32'd2 : 32'd4);

    // Enable low mid-stream, then a load pulse while streaming.
    $display("[TB] enable freeze");
    tap_ready = 1'b0;
    applyStimulus(32'h07_00_03_01);
    tick();
    tap_ready = 1'b1;
    ena       = 1'b0;
    repeat (3) begin
      tick();
      checkOutput("freeze_valid", {31'd0, tap_valid}, 32'd1);
      checkOutput("freeze_out", {24'd0, tap_out}, 32'h01);
      checkOutput("freeze_idx", {24'd0, tap_idx}, 32'd0);
      checkOutput("freeze_cnt", {24'd0, emit_cnt}, 32'd0);
      checkOutput("freeze_busy", {31'd0, busy}, 32'd1);
    end
    ena       = 1'b1;
    tap_ready = 1'b0;
    taps_in   = 32'hFF_FF_FF_FF;
    load      = 1'b1;
    tick();
    load      = 1'b0;
    tap_ready = 1'b1;
    waitDone(40);
    finishLoad();

    // Randomized loads with random ready and enable.
    $display("[TB] random loads");
    repeat (30) begin
      for (int b = 0; b < N; b++) begin
        vec[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      tap_ready = 1'($urandom_range(0, 1));
      applyStimulus(vec);
      n = 0;
      while (!done && n < 300) begin
        tap_ready = 1'($urandom_range(0, 1));
        ena       = ($urandom_range(0, 4) != 0);
        tick();
        n++;
      end
      ena       = 1'b1;
      tap_ready = 1'b1;
      checkOutput("rand_done", {31'd0, done}, 32'd1);
      finishLoad();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
